// File: rtl/snake_tile_renderer.sv
// Snake board renderer: composites snake body, head and food tiles over a background
// pixel stream, using a per-tile-row occupancy bitmap built one row ahead by a scan FSM.
module snake_tile_renderer #(
   parameter  int GRID_W   = 10,
   parameter  int GRID_H   = 10,
   parameter  int TILE     = 40,
   parameter  int ORIGIN_X = 48,
   parameter  int ORIGIN_Y = 48,
   parameter  int MAX_SEG  = 100,
   parameter  int COORD_W  = 8,
   parameter  int COLOR_W  = 12,
   localparam int CNT_W    = $clog2(MAX_SEG + 1),
   localparam int ADDR_W   = $clog2(MAX_SEG)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               line_start,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   input  logic               active_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic [COLOR_W-1:0] bg_color,
   input  logic [COLOR_W-1:0] snake_color,
   input  logic [COLOR_W-1:0] head_color,
   input  logic [COLOR_W-1:0] food_color,
   input  logic [COORD_W-1:0] food_x,
   input  logic [COORD_W-1:0] food_y,
   input  logic [CNT_W-1:0]   seg_count,
   output logic               seg_rd_en,
   output logic [ADDR_W-1:0]  seg_rd_addr,
   input  logic [COORD_W-1:0] seg_x,
   input  logic [COORD_W-1:0] seg_y,
   output logic [COLOR_W-1:0] pixel_color,
   output logic               active_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               scan_overrun
);

   localparam int COL_W = $clog2(GRID_W + 1);
   localparam int ROW_W = $clog2(GRID_H + 1);
   localparam int SUB_W = $clog2(TILE);
   localparam int IDX_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r;
   logic [COL_W-1:0]   col_r;
   logic [SUB_W-1:0]   sub_r;
   logic               col_on_r;
   logic [ROW_W-1:0]   row_r;
   logic [SUB_W-1:0]   subrow_r;
   logic               row_on_r;
   logic [GRID_W-1:0]  front_bits_r;
   logic [COL_W-1:0]   front_head_col_r;
   logic               front_head_valid_r;
   logic [GRID_W-1:0]  back_bits_r;
   logic [COL_W-1:0]   back_head_col_r;
   logic               back_head_valid_r;
   logic               back_ready_r;
   logic [ROW_W-1:0]   target_row_r;
   logic [CNT_W-1:0]   n_r;
   logic               pend_r;
   logic [ADDR_W-1:0]  pend_idx_r;
   logic               active_d1_r;
   logic               hsync_d1_r;
   logic               vsync_d1_r;
   logic [COLOR_W-1:0] bg_d1_r;

   logic               origin_line_s;
   logic               advance_s;
   logic               wrap_s;
   logic               swap_s;
   logic [ROW_W-1:0]   k_s;
   logic               scan_next_s;
   logic [CNT_W-1:0]   n_s;
   logic               seg_ok_s;
   logic               head_hit_s;
   logic [GRID_W-1:0]  hit_mask_s;
   logic               in_board_s;
   logic [COLOR_W-1:0] color_s;

   assign origin_line_s = line_start && (pix_y == 10'(ORIGIN_Y));
   assign advance_s     = line_start && !origin_line_s && row_on_r && (row_r < ROW_W'(GRID_H));
   assign wrap_s        = advance_s && (subrow_r == SUB_W'(TILE - 1));
   // k_s is the tile row whose first line is starting; only rows inside the board swap.
   assign swap_s        = !frame_start &&
                          (origin_line_s || (wrap_s && (row_r < ROW_W'(GRID_H - 1))));
   assign k_s           = origin_line_s ? ROW_W'(0) : (row_r + ROW_W'(1));
   assign scan_next_s   = swap_s && (k_s < ROW_W'(GRID_H - 1));
   assign n_s           = (seg_count > CNT_W'(MAX_SEG)) ? CNT_W'(MAX_SEG) : seg_count;

   assign seg_ok_s   = pend_r &&
                       (seg_x != {COORD_W{1'b1}}) && (seg_y != {COORD_W{1'b1}}) &&
                       (seg_x < COORD_W'(GRID_W)) && (seg_y == COORD_W'(target_row_r));
   assign head_hit_s = seg_ok_s && (pend_idx_r == ADDR_W'(0));

   // Decode the returned segment column into a one-hot bitmap contribution.
   always_comb begin
      hit_mask_s = {GRID_W{1'b0}};
      for (int b = 0; b < GRID_W; b++) begin
         hit_mask_s[b] = seg_ok_s && (seg_x == COORD_W'(b));
      end
   end

   // Tile classification of the pixel held in pipeline stage 1.
   always_comb begin
      color_s    = bg_d1_r;
      in_board_s = col_on_r && (col_r < COL_W'(GRID_W)) &&
                   row_on_r && (row_r < ROW_W'(GRID_H));
      if (!in_board_s) begin
         color_s = bg_d1_r;
      end else if (front_head_valid_r && (col_r == front_head_col_r)) begin
         color_s = head_color;
      end else if (front_bits_r[col_r[IDX_W-1:0]]) begin
         color_s = snake_color;
      end else if ((COORD_W'(row_r) == food_y) && (COORD_W'(col_r) == food_x)) begin
         color_s = food_color;
      end else begin
         color_s = bg_d1_r;
      end
   end

   // Column and row tile counters; a new frame keeps rows out of board until the origin line.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_r    <= COL_W'(0);
         sub_r    <= SUB_W'(0);
         col_on_r <= 1'b0;
         row_r    <= ROW_W'(0);
         subrow_r <= SUB_W'(0);
         row_on_r <= 1'b0;
      end else begin
         if (pix_x == 10'(ORIGIN_X)) begin
            col_r    <= COL_W'(0);
            sub_r    <= SUB_W'(0);
            col_on_r <= 1'b1;
         end else if (col_on_r && (col_r < COL_W'(GRID_W))) begin
            if (sub_r == SUB_W'(TILE - 1)) begin
               sub_r <= SUB_W'(0);
               col_r <= col_r + COL_W'(1);
            end else begin
               sub_r <= sub_r + SUB_W'(1);
            end
         end
         if (frame_start) begin
            row_on_r <= 1'b0;
         end else if (origin_line_s) begin
            row_r    <= ROW_W'(0);
            subrow_r <= SUB_W'(0);
            row_on_r <= 1'b1;
         end else if (advance_s) begin
            if (wrap_s) begin
               subrow_r <= SUB_W'(0);
               row_r    <= row_r + ROW_W'(1);
            end else begin
               subrow_r <= subrow_r + SUB_W'(1);
            end
         end
      end
   end

   // Scan FSM, double-buffered bitmap and row-boundary swap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r            <= IDLE;
         seg_rd_en          <= 1'b0;
         seg_rd_addr        <= ADDR_W'(0);
         n_r                <= CNT_W'(0);
         pend_r             <= 1'b0;
         pend_idx_r         <= ADDR_W'(0);
         target_row_r       <= ROW_W'(0);
         back_bits_r        <= {GRID_W{1'b0}};
         back_head_col_r    <= COL_W'(0);
         back_head_valid_r  <= 1'b0;
         back_ready_r       <= 1'b0;
         front_bits_r       <= {GRID_W{1'b0}};
         front_head_col_r   <= COL_W'(0);
         front_head_valid_r <= 1'b0;
         scan_overrun       <= 1'b0;
      end else begin
         pend_r     <= seg_rd_en;
         pend_idx_r <= seg_rd_addr;

         case (state_r)
            IDLE: begin
               seg_rd_en <= 1'b0;
            end
            READ: begin
               back_bits_r <= back_bits_r | hit_mask_s;
               if (head_hit_s) begin
                  back_head_col_r   <= seg_x[COL_W-1:0];
                  back_head_valid_r <= 1'b1;
               end
               if (seg_rd_addr == ADDR_W'(n_r - CNT_W'(1))) begin
                  seg_rd_en <= 1'b0;
                  state_r   <= DRAIN;
               end else begin
                  seg_rd_addr <= seg_rd_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               back_bits_r <= back_bits_r | hit_mask_s;
               if (head_hit_s) begin
                  back_head_col_r   <= seg_x[COL_W-1:0];
                  back_head_valid_r <= 1'b1;
               end
               state_r <= DONE;
            end
            DONE: begin
               back_ready_r <= 1'b1;
               state_r      <= IDLE;
            end
            default: begin
               seg_rd_en <= 1'b0;
               state_r   <= IDLE;
            end
         endcase

         if (swap_s) begin
            if (back_ready_r && (target_row_r == k_s)) begin
               front_bits_r       <= back_bits_r;
               front_head_col_r   <= back_head_col_r;
               front_head_valid_r <= back_head_valid_r;
               back_ready_r       <= 1'b0;
            end else begin
               front_bits_r       <= {GRID_W{1'b0}};
               front_head_col_r   <= COL_W'(0);
               front_head_valid_r <= 1'b0;
               scan_overrun       <= 1'b1;
            end
         end

         // Starting a scan overrides whatever the FSM and back buffer were doing.
         if (frame_start || scan_next_s) begin
            target_row_r      <= frame_start ? ROW_W'(0) : (k_s + ROW_W'(1));
            n_r               <= n_s;
            seg_rd_addr       <= ADDR_W'(0);
            pend_r            <= 1'b0;
            back_bits_r       <= {GRID_W{1'b0}};
            back_head_col_r   <= COL_W'(0);
            back_head_valid_r <= 1'b0;
            back_ready_r      <= 1'b0;
            if (n_s == CNT_W'(0)) begin
               seg_rd_en <= 1'b0;
               state_r   <= DONE;
            end else begin
               seg_rd_en <= 1'b1;
               state_r   <= READ;
            end
         end
      end
   end

   // Two-stage pixel pipeline: stage 1 aligns with the tile counters, stage 2 drives the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_d1_r <= 1'b0;
         hsync_d1_r  <= 1'b0;
         vsync_d1_r  <= 1'b0;
         bg_d1_r     <= COLOR_W'(0);
         active_out  <= 1'b0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         pixel_color <= COLOR_W'(0);
      end else begin
         active_d1_r <= active_in;
         hsync_d1_r  <= hsync_in;
         vsync_d1_r  <= vsync_in;
         bg_d1_r     <= bg_color;
         active_out  <= active_d1_r;
         hsync_out   <= hsync_d1_r;
         vsync_out   <= vsync_d1_r;
         pixel_color <= active_d1_r ? color_s : COLOR_W'(0);
      end
   end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed bench for snake_tile_renderer: drives compressed video lines and a one-cycle
// latency segment memory, and checks composited pixels, scan behaviour and error flag.
module tb_snake_tile_renderer;

   localparam logic [11:0] BG    = 12'h123;
   localparam logic [11:0] SNAKE = 12'h0F0;
   localparam logic [11:0] HEAD  = 12'hFF0;
   localparam logic [11:0] FOOD  = 12'hF00;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start, line_start;
   logic [9:0]  pix_x, pix_y;
   logic        active_in, hsync_in, vsync_in;
   logic [11:0] bg_color, snake_color, head_color, food_color;
   logic [7:0]  food_x, food_y;
   logic [6:0]  seg_count;
   logic        seg_rd_en;
   logic [6:0]  seg_rd_addr;
   logic [7:0]  seg_x = 8'd0, seg_y = 8'd0;
   logic [11:0] pixel_color;
   logic        active_out, hsync_out, vsync_out, scan_overrun;

   logic [7:0]  mem_x [0:127];
   logic [7:0]  mem_y [0:127];
   int          rd_pulses = 0;
   int          base;
   int          cur_y;
   int          passed = 0;
   int          total  = 0;

   snake_tile_renderer dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
      .pix_x(pix_x), .pix_y(pix_y), .active_in(active_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .bg_color(bg_color), .snake_color(snake_color),
      .head_color(head_color), .food_color(food_color), .food_x(food_x), .food_y(food_y),
      .seg_count(seg_count), .seg_rd_en(seg_rd_en), .seg_rd_addr(seg_rd_addr),
      .seg_x(seg_x), .seg_y(seg_y), .pixel_color(pixel_color), .active_out(active_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .scan_overrun(scan_overrun)
   );

   always #5 clk = ~clk;

   // Segment memory with one cycle of read latency.
   always @(posedge clk) begin
      if (seg_rd_en) begin
         seg_x <= mem_x[seg_rd_addr];
         seg_y <= mem_y[seg_rd_addr];
      end
   end

   always @(posedge clk) begin
      if (seg_rd_en) rd_pulses <= rd_pulses + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) begin
         mem_x[i] = 8'hFF;
         mem_y[i] = 8'hFF;
      end
   endtask

   task automatic new_frame();
      frame_start = 1'b1;
      pix_y = 10'd0;
      @(negedge clk);
      frame_start = 1'b0;
      cur_y = 0;
   endtask

   task automatic short_line(input int gap);
      line_start = 1'b1;
      pix_y = 10'(cur_y);
      pix_x = 10'd0;
      active_in = 1'b0;
      @(negedge clk);
      line_start = 1'b0;
      repeat (gap) @(negedge clk);
      cur_y++;
   endtask

   task automatic goto_y(input int y, input int gap);
      while (cur_y < y) short_line(gap);
   endtask

   task automatic px_line(input int x_end, input logic [11:0] expv, input string tag);
      line_start = 1'b1;
      pix_y = 10'(cur_y);
      pix_x = 10'd0;
      active_in = 1'b0;
      @(negedge clk);
      line_start = 1'b0;
      for (int x = 48; x <= x_end; x++) begin
         pix_x = 10'(x);
         active_in = 1'b1;
         @(negedge clk);
      end
      active_in = 1'b0;
      pix_x = 10'(x_end + 1);
      @(negedge clk);
      chk(tag, 32'(pixel_color), 32'(expv));
      cur_y++;
   endtask

   initial begin
      reset = 1'b1;
      frame_start = 1'b0; line_start = 1'b0;
      pix_x = 10'd0; pix_y = 10'd0;
      active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      bg_color = BG; snake_color = SNAKE; head_color = HEAD; food_color = FOOD;
      food_x = 8'd9; food_y = 8'd9;
      seg_count = 7'd0;
      cur_y = 0;
      clear_mem();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset held for 3 cycles in the middle of a long scan.
      mem_x[0] = 8'd3; mem_y[0] = 8'd0;
      seg_count = 7'd100;
      new_frame();
      repeat (10) @(negedge clk);
      chk("rd_en_midscan", 32'(seg_rd_en), 32'd1);
      reset = 1'b1;
      active_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_pixel", 32'(pixel_color), 32'd0);
      chk("rst_active", 32'(active_out), 32'd0);
      chk("rst_hsync", 32'(hsync_out), 32'd0);
      chk("rst_vsync", 32'(vsync_out), 32'd0);
      chk("rst_rd_en", 32'(seg_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(seg_rd_addr), 32'd0);
      chk("rst_overrun", 32'(scan_overrun), 32'd0);
      reset = 1'b0;
      active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      goto_y(48, 2);
      px_line(168, BG, "no_commit_px");
      chk("no_commit_overrun", 32'(scan_overrun), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Basic snake: head (3,0), body (4,0) and (4,1).
      clear_mem();
      mem_x[0] = 8'd3; mem_y[0] = 8'd0;
      mem_x[1] = 8'd4; mem_y[1] = 8'd0;
      mem_x[2] = 8'd4; mem_y[2] = 8'd1;
      mem_x[3] = 8'd1; mem_y[3] = 8'd2;
      seg_count = 7'd3;
      food_x = 8'd7; food_y = 8'd7;
      base = rd_pulses;
      new_frame();
      repeat (8) @(negedge clk);
      chk("pulses_n3", 32'(rd_pulses - base), 32'd3);
      goto_y(48, 2);
      px_line(168, HEAD, "head_3_0");
      px_line(208, SNAKE, "body_4_0");
      px_line(248, BG, "bg_5_0");
      px_line(167, BG, "col_edge_167");
      goto_y(88, 2);
      px_line(208, SNAKE, "body_4_1");
      px_line(168, BG, "row1_col3_bg");
      chk("overrun_clean", 32'(scan_overrun), 32'd0);
      hsync_in = 1'b1; vsync_in = 1'b0;
      @(negedge clk);
      hsync_in = 1'b0; vsync_in = 1'b1;
      @(negedge clk);
      chk("hsync_delay", 32'(hsync_out), 32'd1);
      chk("vsync_low", 32'(vsync_out), 32'd0);
      vsync_in = 1'b0;
      @(negedge clk);
      chk("vsync_delay", 32'(vsync_out), 32'd1);
      chk("hsync_low", 32'(hsync_out), 32'd0);
      chk("blank_pixel", 32'(pixel_color), 32'd0);

      // Empty snake, food only at (2,2).
      seg_count = 7'd0;
      food_x = 8'd2; food_y = 8'd2;
      base = rd_pulses;
      new_frame();
      repeat (4) @(negedge clk);
      chk("pulses_n0", 32'(rd_pulses - base), 32'd0);
      goto_y(127, 2);
      px_line(128, BG, "food_above");
      px_line(128, FOOD, "food_tl");
      px_line(167, FOOD, "food_right_edge");
      px_line(168, BG, "food_right_out");
      px_line(127, BG, "food_left_out");
      goto_y(167, 2);
      px_line(150, FOOD, "food_bottom_edge");
      px_line(150, BG, "food_below");
      chk("pulses_n0_rows", 32'(rd_pulses - base), 32'd0);

      // Priority and invalid entries.
      clear_mem();
      mem_x[0] = 8'd5;  mem_y[0] = 8'd5;
      mem_x[1] = 8'd255; mem_y[1] = 8'd255;
      mem_x[2] = 8'd10; mem_y[2] = 8'd0;
      mem_x[3] = 8'd6;  mem_y[3] = 8'd5;
      seg_count = 7'd4;
      food_x = 8'd5; food_y = 8'd5;
      base = rd_pulses;
      new_frame();
      repeat (10) @(negedge clk);
      chk("pulses_n4", 32'(rd_pulses - base), 32'd4);
      goto_y(48, 2);
      px_line(48, BG, "gridw_no_wrap_c0");
      px_line(128, BG, "gridw_no_wrap_c2");
      goto_y(248, 2);
      px_line(248, HEAD, "head_over_food");
      food_x = 8'd6;
      px_line(288, SNAKE, "body_over_food");
      px_line(328, BG, "row5_col7_bg");
      food_x = 8'd7;
      px_line(328, FOOD, "food_7_5");

      // Long scan stalled past a tile-row boundary.
      clear_mem();
      mem_x[0] = 8'd3; mem_y[0] = 8'd0;
      mem_x[1] = 8'd4; mem_y[1] = 8'd0;
      mem_x[2] = 8'd4; mem_y[2] = 8'd1;
      mem_x[3] = 8'd1; mem_y[3] = 8'd2;
      seg_count = 7'd100;
      food_x = 8'd9; food_y = 8'd9;
      new_frame();
      goto_y(49, 2);
      chk("overrun_before_stall", 32'(scan_overrun), 32'd0);
      goto_y(88, 1);
      px_line(208, BG, "overrun_row_no_snake");
      chk("overrun_set", 32'(scan_overrun), 32'd1);
      goto_y(128, 2);
      px_line(88, SNAKE, "row2_after_overrun");
      chk("overrun_sticky", 32'(scan_overrun), 32'd1);

      // frame_start in the middle of a scan restarts at address 0.
      new_frame();
      repeat (20) @(negedge clk);
      chk("addr_before_restart", 32'(seg_rd_addr), 32'd20);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("addr_restart", 32'(seg_rd_addr), 32'd0);
      chk("rd_en_restart", 32'(seg_rd_en), 32'd1);
      cur_y = 0;
      goto_y(48, 2);
      px_line(168, HEAD, "restart_head");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
